// File: rtl/crc_byte_feeder_if.sv
// crc_byte_feeder_if: bus-side and engine-side signals of the CRC byte feeder.
//   master : drives writes, flush, clear and the engine status (busy/done);
//            observes wr_ready, the byte stream, data_done, level, overflow.
//   slave  : the feeder itself.
// DEPTH must match the DEPTH of the crc_byte_feeder attached to this interface.
interface crc_byte_feeder_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [1:0]    wr_size;
  logic [31:0]   wr_data;
  logic          flush;
  logic          clear;
  logic          crc_busy;
  logic          crc_done;
  logic          wr_ready;
  logic          crc_trigger;
  logic [7:0]    crc_byte;
  logic          data_done;
  logic [LW-1:0] level;
  logic          overflow;

  modport master (
    output wr_en, wr_size, wr_data, flush, clear, crc_busy, crc_done,
    input  wr_ready, crc_trigger, crc_byte, data_done, level, overflow
  );

  modport slave (
    input  wr_en, wr_size, wr_data, flush, clear, crc_busy, crc_done,
    output wr_ready, crc_trigger, crc_byte, data_done, level, overflow
  );
endinterface

// File: rtl/crc_byte_feeder.sv
// crc_byte_feeder: queues 8/16/32-bit bus writes in a small word FIFO and
// feeds them LSB-first, one byte at a time, into the CRC engine.
// Ports:
//   clk, rst   : single clock, synchronous active-high reset
//   bus        : crc_byte_feeder_if slave (writes, flush, clear, engine
//                handshake, wr_ready, byte stream, data_done, level, overflow)
//   dbg_state  : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
//
// Handshakes:
//   - A write is taken in any cycle with wr_en & wr_ready & (wr_size != 11);
//     wr_ready depends only on the registered level, so a pop in the same
//     cycle never frees room for that cycle's write. A write with
//     wr_en & !wr_ready & (wr_size != 11) is dropped and sets overflow.
//   - A byte is offered to the engine only when the engine is not busy:
//     crc_trigger pulses for one cycle with crc_byte valid, then the feeder
//     waits (without timeout) for the engine's crc_done before moving on.
module crc_byte_feeder #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  crc_byte_feeder_if.slave   bus,
  output logic [1:0]         dbg_state
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [1:0]    size_q [DEPTH];
  logic [1:0]    size_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    idx_q, idx_d;
  logic          trig_q, trig_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          flush_pend_q, flush_pend_d;

  logic          wr_ready;
  logic          wr_valid;
  logic          push;
  logic          drop;
  logic          pop;
  logic          empty;
  logic          done_fire;
  logic [31:0]   head_data;
  logic [1:0]    head_size;
  logic [1:0]    last_idx;
  logic [7:0]    cur_byte;

  assign wr_ready  = (level_q != LW'(DEPTH));
  assign wr_valid  = bus.wr_en & (bus.wr_size != 2'b11);
  assign push      = wr_valid & wr_ready;
  assign drop      = wr_valid & ~wr_ready;
  assign empty     = (level_q == '0);
  assign head_data = data_q[rd_ptr_q];
  assign head_size = size_q[rd_ptr_q];

  // Stored size code 00/01/10 means 1/2/4 bytes; last byte index 0/1/3.
  always_comb begin
    case (head_size)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = head_data[7:0];
      2'd1:    cur_byte = head_data[15:8];
      2'd2:    cur_byte = head_data[23:16];
      default: cur_byte = head_data[31:24];
    endcase
  end

  // The head entry leaves the FIFO when the engine finishes its last byte.
  assign pop       = (state_q == WAIT) & bus.crc_done & (idx_q == last_idx);
  // End of message: nothing queued and nothing in flight (the FSM only
  // leaves IDLE while the FIFO holds an entry).
  assign done_fire = (state_q == IDLE) & empty & flush_pend_q;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    size_d       = size_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    idx_d        = idx_q;
    trig_d       = 1'b0;
    byte_d       = byte_q;
    done_d       = done_fire;
    ovf_d        = ovf_q;
    flush_pend_d = (flush_pend_q & ~done_fire) | bus.flush;

    case (state_q)
      IDLE: begin
        if (!empty && !bus.crc_busy) begin
          state_d = ISSUE;
          trig_d  = 1'b1;
          byte_d  = cur_byte;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.crc_done) begin
          state_d = IDLE;
          if (pop) begin
            idx_d    = 2'd0;
            rd_ptr_d = rd_ptr_q + PW'(1);
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      data_d[wr_ptr_q] = bus.wr_data;
      size_d[wr_ptr_q] = bus.wr_size;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A dropped write in the same cycle as clear keeps overflow set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.clear) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      idx_q        <= '0;
      trig_q       <= 1'b0;
      byte_q       <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      size_q       <= size_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      idx_q        <= idx_d;
      trig_q       <= trig_d;
      byte_q       <= byte_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.crc_trigger = trig_q;
  assign bus.crc_byte    = byte_q;
  assign bus.data_done   = done_q;
  assign bus.level       = level_q;
  assign bus.overflow    = ovf_q;
  assign dbg_state       = state_q;
endmodule
